vscale_core_scheduler: RTL and testbench

Upstream neighbour of the dmem arbiter; generates `next_core`, the arbiter's per-cycle mux selector.
- Round-robin among cores with pending dmem transfers.
- Each owner gets a bounded quantum.
- Switches only at AHB-safe points: `dmem_hready` high, no locked sequence in flight.
- Keeps a shadow `owner` register that mirrors the arbiter's registered `cur_core`.

---
 rtl/vscale_core_scheduler_pkg.sv | 25 ++
 rtl/vscale_core_scheduler_if.sv | 42 ++++
 rtl/vscale_core_scheduler_rr_pick.sv | 38 +++
 rtl/vscale_core_scheduler.sv | 101 ++++++++++
 tb/tb_vscale_core_scheduler.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/vscale_core_scheduler_pkg.sv
// Shared constants for the multicore dmem scheduler: core count, index width,
// HASTI transfer encodings and the default owner quantum.
package vscale_core_scheduler_pkg;

  localparam int SCHED_NUM_CORES      = 4;
  localparam int SCHED_CORE_IDX_WIDTH = 2;
  localparam int SCHED_QUANTUM        = 16;
  localparam int SCHED_CNT_WIDTH      = 5;

  localparam int HASTI_TRANS_WIDTH = 2;

  // AHB-lite htrans encodings; bit 1 set means a real transfer is presented.
  typedef enum logic [HASTI_TRANS_WIDTH-1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } hasti_trans_e;

  // A core is requesting the bus when it drives NONSEQ or SEQ.
  function automatic logic htrans_is_req(input logic [HASTI_TRANS_WIDTH-1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/vscale_core_scheduler_if.sv
// Bundle of per-core dmem request signals seen by the scheduler and the
// selector/status outputs it returns to the arbiter side.
interface vscale_core_scheduler_if
  import vscale_core_scheduler_pkg::*;
#(
  parameter int NUM_CORES      = SCHED_NUM_CORES,
  parameter int CORE_IDX_WIDTH = SCHED_CORE_IDX_WIDTH,
  parameter int CNT_WIDTH      = SCHED_CNT_WIDTH
);

  logic [NUM_CORES-1:0][HASTI_TRANS_WIDTH-1:0] core_htrans;
  logic [NUM_CORES-1:0]                        core_hmastlock;
  logic                                        dmem_hready;

  logic [CORE_IDX_WIDTH-1:0] next_core;
  logic [CORE_IDX_WIDTH-1:0] owner;
  logic                      switch_pulse;
  logic [CNT_WIDTH-1:0]      quantum_cnt;

  // Core/memory side: presents requests and hready, observes the selection.
  modport master (
    output core_htrans,
    output core_hmastlock,
    output dmem_hready,
    input  next_core,
    input  owner,
    input  switch_pulse,
    input  quantum_cnt
  );

  // Scheduler side.
  modport slave (
    input  core_htrans,
    input  core_hmastlock,
    input  dmem_hready,
    output next_core,
    output owner,
    output switch_pulse,
    output quantum_cnt
  );

endinterface

// File: rtl/vscale_core_scheduler_rr_pick.sv
// Rotating priority encoder: finds the first requester strictly after `base`,
// wrapping modulo NUM_CORES (not modulo the index width), so odd core counts
// rotate correctly. `base` itself is never chosen.
module vscale_rr_pick
  import vscale_core_scheduler_pkg::*;
#(
  parameter int NUM_CORES      = SCHED_NUM_CORES,
  parameter int CORE_IDX_WIDTH = SCHED_CORE_IDX_WIDTH
) (
  input  logic [NUM_CORES-1:0]      req,
  input  logic [CORE_IDX_WIDTH-1:0] base,
  output logic                      found,
  output logic [CORE_IDX_WIDTH-1:0] idx
);

  int                        pos_i;
  logic [CORE_IDX_WIDTH-1:0] pos;

  // Scan farthest-to-nearest so the nearest requester after base wins last.
  always_comb begin
    found = 1'b0;
    idx   = base;
    pos_i = 0;
    pos   = '0;
    for (int k = NUM_CORES - 1; k >= 1; k--) begin
      pos_i = int'(base) + k;
      if (pos_i >= NUM_CORES) begin
        pos_i = pos_i - NUM_CORES;
      end
      pos = CORE_IDX_WIDTH'(pos_i);
      if (req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/vscale_core_scheduler.sv
// Round-robin dmem owner scheduler. Produces the arbiter's combinational
// selector `next_core`, keeps a registered shadow of the arbiter's current
// owner, and limits each owner to QUANTUM accepted transfers. Ownership only
// moves at AHB-safe points: hready high and no locked sequence in flight.
// CNT_WIDTH must be wide enough to hold QUANTUM-1, and QUANTUM must be >= 1.
module vscale_core_scheduler
  import vscale_core_scheduler_pkg::*;
#(
  parameter int NUM_CORES      = SCHED_NUM_CORES,
  parameter int CORE_IDX_WIDTH = SCHED_CORE_IDX_WIDTH,
  parameter int QUANTUM        = SCHED_QUANTUM,
  parameter int CNT_WIDTH      = SCHED_CNT_WIDTH
) (
  input logic                    clk,
  input logic                    reset_n,
  vscale_core_scheduler_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(QUANTUM - 1);

  logic [CORE_IDX_WIDTH-1:0] owner_q, owner_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

  logic [NUM_CORES-1:0]      req;
  logic                      unused_htrans_lsb;
  logic                      owner_req;
  logic                      owner_lock;
  logic                      safe;
  logic                      accept;
  logic                      expired;
  logic                      want;
  logic                      do_switch;
  logic                      found;
  logic [CORE_IDX_WIDTH-1:0] cand;

  // Reduce each core's htrans to a request bit; bit 0 only separates IDLE/BUSY
  // and NONSEQ/SEQ, which the scheduler does not care about.
  always_comb begin
    req               = '0;
    unused_htrans_lsb = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      req[i]            = htrans_is_req(bus.core_htrans[i]);
      unused_htrans_lsb = unused_htrans_lsb ^ bus.core_htrans[i][0];
    end
  end

  vscale_rr_pick #(
    .NUM_CORES      (NUM_CORES),
    .CORE_IDX_WIDTH (CORE_IDX_WIDTH)
  ) u_rr_pick (
    .req   (req),
    .base  (owner_q),
    .found (found),
    .idx   (cand)
  );

  // Decide whether ownership moves this cycle and how the quantum counter
  // evolves; an expired quantum under lock saturates until the lock drops.
  always_comb begin
    owner_req  = req[owner_q];
    owner_lock = bus.core_hmastlock[owner_q] & owner_req;
    safe       = bus.dmem_hready & ~owner_lock;
    accept     = bus.dmem_hready & owner_req;
    expired    = accept & (cnt_q == CNT_LAST);
    want       = ~owner_req | expired;
    do_switch  = safe & want & found;

    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (do_switch) begin
      owner_d = cand;
      cnt_d   = '0;
    end else if (expired && !found) begin
      cnt_d = '0;
    end else if (expired && owner_lock) begin
      cnt_d = cnt_q;
    end else if (accept) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Outputs are forced quiet while reset is held so the arbiter sees core 0.
  always_comb begin
    bus.next_core    = reset_n ? owner_d : '0;
    bus.switch_pulse = reset_n & do_switch;
    bus.owner        = owner_q;
    bus.quantum_cnt  = cnt_q;
  end

  // Owner shadow and quantum counter; owner tracks the arbiter's registered cur_core.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_vscale_core_scheduler.sv
// Randomized and directed bench for vscale_core_scheduler with 4 cores and a
// quantum of 4, checked against a behavioural reference model.
module tb_vscale_core_scheduler;
  import vscale_core_scheduler_pkg::*;

  localparam int NC = 4;
  localparam int IW = 2;
  localparam int Q  = 4;
  localparam int CW = 5;

  localparam logic [1:0] I_ = HTRANS_IDLE;
  localparam logic [1:0] B_ = HTRANS_BUSY;
  localparam logic [1:0] N_ = HTRANS_NONSEQ;
  localparam logic [1:0] S_ = HTRANS_SEQ;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int total = 0;
  int bad = 0;
  int m_owner = 0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  vscale_core_scheduler_if #(
    .NUM_CORES      (NC),
    .CORE_IDX_WIDTH (IW),
    .CNT_WIDTH      (CW)
  ) bus ();

  vscale_core_scheduler #(
    .NUM_CORES      (NC),
    .CORE_IDX_WIDTH (IW),
    .QUANTUM        (Q),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Counts one comparison and reports it if the observed value differs.
  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] mk(input logic [1:0] t0, input logic [1:0] t1,
                                    input logic [1:0] t2, input logic [1:0] t3);
    return {t3, t2, t1, t0};
  endfunction

  function automatic bit isReq(input logic [7:0] ht, input int c);
    logic [1:0] t;
    t = ht[2*c +: 2];
    return (t == N_) || (t == S_);
  endfunction

  // Reference: scheduler rules applied to integer owner/count state.
  function automatic void modelStep(input logic [7:0] ht, input logic [3:0] lk, input logic hr,
                                    input int own, input int cnt,
                                    output int nxt, output int ncnt);
    bit oreq, lockv, safev, acc, expv;
    int cand;
    oreq  = isReq(ht, own);
    lockv = lk[own] && oreq;
    safev = hr && !lockv;
    acc   = hr && oreq;
    expv  = acc && (cnt == Q - 1);
    cand  = -1;
    for (int k = 1; k < NC; k++) begin
      if (cand < 0 && isReq(ht, (own + k) % NC)) cand = (own + k) % NC;
    end
    nxt  = own;
    ncnt = cnt;
    if (safev && (!oreq || expv) && cand >= 0) begin
      nxt  = cand;
      ncnt = 0;
    end else if (expv && cand < 0) begin
      ncnt = 0;
    end else if (expv && lockv) begin
      ncnt = cnt;
    end else if (acc) begin
      ncnt = cnt + 1;
    end
  endfunction

  // One clock cycle: drive on the falling edge, check mid-cycle, advance model.
  task automatic applyStimulus(input logic [7:0] ht, input logic [3:0] lk, input logic hr,
                               input string tag);
    int en, ec;
    @(negedge clk);
    bus.core_htrans    = ht;
    bus.core_hmastlock = lk;
    bus.dmem_hready    = hr;
    #1;
    modelStep(ht, lk, hr, m_owner, m_cnt, en, ec);
    checkOutput({tag, ":next_core"}, int'(bus.next_core), en);
    checkOutput({tag, ":switch_pulse"}, int'(bus.switch_pulse), (en != m_owner) ? 1 : 0);
    checkOutput({tag, ":owner"}, int'(bus.owner), m_owner);
    checkOutput({tag, ":quantum_cnt"}, int'(bus.quantum_cnt), m_cnt);
    @(posedge clk);
    m_owner = en;
    m_cnt   = ec;
  endtask

  // Registered state just after a rising edge, against hand-derived values.
  task automatic checkState(input string tag, input int exp_owner, input int exp_cnt);
    #1;
    checkOutput({tag, ":owner"}, int'(bus.owner), exp_owner);
    checkOutput({tag, ":quantum_cnt"}, int'(bus.quantum_cnt), exp_cnt);
  endtask

  // Asserts reset off-edge, checks it acts at once, then releases on a falling edge.
  task automatic doReset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput({tag, ":owner"}, int'(bus.owner), 0);
    checkOutput({tag, ":quantum_cnt"}, int'(bus.quantum_cnt), 0);
    checkOutput({tag, ":next_core"}, int'(bus.next_core), 0);
    checkOutput({tag, ":switch_pulse"}, int'(bus.switch_pulse), 0);
    bus.core_htrans    = mk(I_, I_, I_, I_);
    bus.core_hmastlock = '0;
    bus.dmem_hready    = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    m_owner = 0;
    m_cnt   = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] rht;
    logic [3:0] rlk;
    logic       rhr;

    bus.core_htrans    = mk(N_, S_, N_, N_);
    bus.core_hmastlock = '0;
    bus.dmem_hready    = 1'b1;
    reset_n            = 1'b0;
    doReset("reset");

    $display("[TB] all cores idle");
    for (int i = 0; i < 10; i++) applyStimulus(mk(I_, I_, I_, I_), 4'b0000, 1'b1, "idle");

    $display("[TB] cores 0 and 2 streaming");
    for (int i = 0; i < 16; i++) applyStimulus(mk(N_, I_, N_, I_), 4'b0000, 1'b1, "rr02");
    checkState("rr02_end", 0, 0);

    $display("[TB] wait states at quantum boundary");
    doReset("reset_ws");
    for (int i = 0; i < 3; i++) applyStimulus(mk(N_, I_, I_, I_), 4'b0000, 1'b1, "ws_fill");
    checkState("ws_full", 0, 3);
    for (int i = 0; i < 3; i++) applyStimulus(mk(N_, N_, I_, I_), 4'b0000, 1'b0, "ws_wait");
    applyStimulus(mk(N_, N_, I_, I_), 4'b0000, 1'b1, "ws_go");
    checkState("ws_after", 1, 0);

    $display("[TB] locked owner 3");
    doReset("reset_lk");
    applyStimulus(mk(I_, I_, I_, N_), 4'b0000, 1'b1, "lk_take");
    checkState("lk_taken", 3, 0);
    for (int i = 0; i < 7; i++) applyStimulus(mk(I_, N_, I_, S_), 4'b1000, 1'b1, "lk_hold");
    checkState("lk_sat", 3, 3);
    applyStimulus(mk(I_, N_, I_, S_), 4'b0000, 1'b1, "lk_drop");
    checkState("lk_after", 1, 0);

    $display("[TB] owner goes idle");
    doReset("reset_idle");
    applyStimulus(mk(I_, N_, I_, I_), 4'b0000, 1'b1, "oi_take");
    applyStimulus(mk(I_, N_, I_, I_), 4'b0000, 1'b1, "oi_acc");
    checkState("oi_mid", 1, 1);
    applyStimulus(mk(N_, B_, I_, I_), 4'b0000, 1'b1, "oi_idle");
    checkState("oi_after", 0, 0);

    $display("[TB] reset mid-run");
    doReset("reset_mr0");
    for (int i = 0; i < 3; i++) applyStimulus(mk(I_, I_, N_, I_), 4'b0000, 1'b1, "mr_run");
    checkState("mr_pre", 2, 2);
    bus.core_htrans = mk(I_, N_, N_, I_);
    doReset("reset_mid");

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      rht = 8'($urandom);
      rlk = 4'($urandom & $urandom);
      rhr = ($urandom_range(0, 3) != 0);
      applyStimulus(rht, rlk, rhr, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
